vending_arbiter: RTL and testbench

Round-robin arbiter that shares one `vending_machine_moore` core among `N_PORT` coin-entry ports. It owns the core's `coin` input and routes the core's `sell`/`change` back to the port currently holding the grant. A grant is held for one complete sale, from the first coin until `sell`, then released and re-arbitrated. It sits directly in front of the machine core and is reset by the same `rstn`.

---
 rtl/vending_arbiter.sv | 142 ++++++++++++++
 tb/tb_vending_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_arbiter.sv
// Round-robin arbiter sharing one vending machine core among N_PORT coin ports.
// Optional saturating sale counter on port sale_cnt when VM_ARB_SALE_CNT_EN is defined.
module vending_arbiter #(
  parameter int N_PORT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_PORT-1:0]     req,
  input  logic [2*N_PORT-1:0]   coin_in,
  output logic [N_PORT-1:0]     gnt,
  output logic                  busy,
  output logic [1:0]            vm_coin,
  input  logic                  vm_sell,
  input  logic [1:0]            vm_change,
  output logic [N_PORT-1:0]     sell_o,
  output logic [2*N_PORT-1:0]   change_o,
  output logic                  coin_err
`ifdef VM_ARB_SALE_CNT_EN
  ,
  output logic [CNT_W-1:0]      sale_cnt
`endif
);

  localparam int PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [N_PORT-1:0]   gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                coin_err_q, coin_err_d;

  logic                win_valid;
  logic [PW-1:0]       win_idx;
  logic [PW:0]         cand;
  logic [PW:0]         nxt;
  logic [1:0]          coin_sel;

  // First requester at or after ptr, searching upward with wrap-around.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_PORT; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_PORT)) cand = cand - (PW+1)'(N_PORT);
      if (!win_valid && req[cand[PW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
    nxt = {1'b0, win_idx} + (PW+1)'(1);
    if (nxt >= (PW+1)'(N_PORT)) nxt = '0;
  end

  assign coin_sel = coin_in[{gidx_q, 1'b0} +: 2];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    gnt_d      = gnt_q;
    coin_err_d = (state_q == GRANT) && (coin_sel == 2'b11);
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d        = GRANT;
          gidx_d         = win_idx;
          ptr_d          = nxt[PW-1:0];
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (vm_sell) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      coin_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      coin_err_q <= coin_err_d;
    end
  end

  // A coin coinciding with sell is dropped; the core is closing the sale.
  always_comb begin
    vm_coin  = 2'b00;
    sell_o   = '0;
    change_o = '0;
    if (state_q == GRANT) begin
      if (!vm_sell && coin_sel != 2'b11) vm_coin = coin_sel;
      sell_o[gidx_q]                  = vm_sell;
      change_o[{gidx_q, 1'b0} +: 2]   = vm_change;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign coin_err = coin_err_q;

`ifdef VM_ARB_SALE_CNT_EN
  logic [CNT_W-1:0] sale_cnt_q, sale_cnt_d;

  always_comb begin
    sale_cnt_d = sale_cnt_q;
    if (state_q == GRANT && vm_sell && sale_cnt_q != {CNT_W{1'b1}})
      sale_cnt_d = sale_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sale_cnt_q <= '0;
    else       sale_cnt_q <= sale_cnt_d;
  end

  assign sale_cnt = sale_cnt_q;
`endif

endmodule

// File: tb/tb_vending_arbiter.sv
// Bench for vending_arbiter: directed scenarios plus random traffic against a reference model,
// with a simple price-2.0 machine core model driving vm_sell/vm_change.
module tb_vending_arbiter;

  localparam int N = 4;
  localparam int CW = 16;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   req;
  logic [2*N-1:0] coin_in;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [1:0]     vm_coin;
  logic           vm_sell;
  logic [1:0]     vm_change;
  logic [N-1:0]   sell_o;
  logic [2*N-1:0] change_o;
  logic           coin_err;
`ifdef VM_ARB_SALE_CNT_EN
  logic [CW-1:0]  sale_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  vending_arbiter #(.N_PORT(N), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .coin_in(coin_in),
    .gnt(gnt), .busy(busy), .vm_coin(vm_coin),
    .vm_sell(vm_sell), .vm_change(vm_change),
    .sell_o(sell_o), .change_o(change_o), .coin_err(coin_err)
`ifdef VM_ARB_SALE_CNT_EN
    , .sale_cnt(sale_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Machine core model: price 2.0 (four halves), sells one cycle after credit reaches price.
  int core_credit;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_credit <= 0;
      vm_sell     <= 1'b0;
      vm_change   <= 2'b00;
    end else if (vm_sell) begin
      core_credit <= 0;
      vm_sell     <= 1'b0;
      vm_change   <= 2'b00;
    end else if (core_credit + int'(vm_coin) >= 4) begin
      core_credit <= 0;
      vm_sell     <= 1'b1;
      vm_change   <= 2'(core_credit + int'(vm_coin) - 4);
    end else begin
      core_credit <= core_credit + int'(vm_coin);
    end
  end

  // Reference model: granted port (-1 = none), rotating pointer, error flag, sales.
  int m_g, m_ptr, m_cnt;
  bit m_err;

  function automatic logic [N-1:0] exp_gnt();
    return (m_g < 0) ? '0 : N'(1 << m_g);
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic s, input logic [1:0] cg);
    m_err = (m_g >= 0) && (cg == 2'b11);
    if (m_g < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_g < 0 && r[idx]) begin
          m_g   = idx;
          m_ptr = (idx + 1) % N;
        end
      end
    end else if (s) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      m_g = -1;
    end
  endtask

  task automatic tick();
    logic [N-1:0] r;
    logic         s;
    logic [1:0]   cg;
    r  = req;
    s  = vm_sell;
    cg = (m_g >= 0) ? coin_in[2*m_g +: 2] : 2'b00;
    @(posedge clk);
    model_edge(r, s, cg);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn    = 1'b0;
    req     = '0;
    coin_in = '0;
    m_g = -1; m_ptr = 0; m_cnt = 0; m_err = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_coin(input int p, input logic [1:0] c);
    coin_in = '0;
    coin_in[2*p +: 2] = c;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if (gnt !== '0 || busy !== 1'b0 || coin_err !== 1'b0 || vm_coin !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b busy=%b coin_err=%b vm_coin=%b, required all zero",
               gnt, busy, coin_err, vm_coin);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    n_assert++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b busy=%b, required 0100/1", gnt, busy);
    end
    for (int i = 0; i < 4; i++) begin
      set_coin(2, 2'b01);
      #1;
      n_assert++;
      if (vm_coin !== 2'b01) begin
        n_fail++;
        $display("FAIL single_coin%0d: vm_coin=%b, required 01", i, vm_coin);
      end
      tick();
    end
    coin_in = '0;
    #1;
    n_assert++;
    if (vm_sell !== 1'b1 || sell_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_sell: vm_sell=%b sell_o=%b, required 1/0100", vm_sell, sell_o);
    end
    req = '0;
    tick();
    n_assert++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: gnt=%b busy=%b, required 0000/0", gnt, busy);
    end
`ifdef VM_ARB_SALE_CNT_EN
    n_assert++;
    if (sale_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_sale_cnt: sale_cnt=%0d, required 1", sale_cnt);
    end
`endif
  endtask

  task automatic test_contention();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      int p;
      p = order[i];
      n_assert++;
      if (gnt !== 4'(1 << p)) begin
        n_fail++;
        $display("FAIL contention_grant%0d: gnt=%b, required port %0d", i, gnt, p);
      end
      set_coin(p, 2'b10); tick();
      set_coin(p, 2'b10); tick();
      coin_in = '0;
      #1;
      n_assert++;
      if (sell_o !== 4'(1 << p)) begin
        n_fail++;
        $display("FAIL contention_sell%0d: sell_o=%b, required port %0d", i, sell_o, p);
      end
      tick();
      n_assert++;
      if (gnt !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_idle%0d: gnt=%b busy=%b, required 0000/0", i, gnt, busy);
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_change();
    logic [1:0] seq [3] = '{2'b10, 2'b01, 2'b10};
    do_reset();
    req = 4'b0010;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_coin(1, seq[i]);
      tick();
    end
    coin_in = '0;
    #1;
    n_assert++;
    if (sell_o !== 4'b0010 || change_o !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL change_route: sell_o=%b change_o=%b, required 0010/00000100", sell_o, change_o);
    end
    req = '0;
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    req = 4'b1000;
    tick();
    set_coin(3, 2'b11);
    #1;
    n_assert++;
    if (vm_coin !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_vm_coin: vm_coin=%b, required 00", vm_coin);
    end
    tick();
    coin_in = '0;
    n_assert++;
    if (coin_err !== 1'b1 || gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL illegal_err_pulse: coin_err=%b gnt=%b, required 1/1000", coin_err, gnt);
    end
    tick();
    n_assert++;
    if (coin_err !== 1'b0 || gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL illegal_err_end: coin_err=%b gnt=%b, required 0/1000", coin_err, gnt);
    end
    req = '0;
  endtask

  task automatic test_midsale_reset();
    do_reset();
    req = 4'b0001;
    tick();
    set_coin(0, 2'b01);
    tick();
    set_coin(0, 2'b10);
    #2;
    rstn = 1'b0;
    #1;
    n_assert++;
    if (gnt !== '0 || busy !== 1'b0 || vm_coin !== 2'b00) begin
      n_fail++;
      $display("FAIL midsale_reset: gnt=%b busy=%b vm_coin=%b, required zero", gnt, busy, vm_coin);
    end
`ifdef VM_ARB_SALE_CNT_EN
    n_assert++;
    if (sale_cnt !== '0) begin
      n_fail++;
      $display("FAIL midsale_reset_cnt: sale_cnt=%0d, required 0", sale_cnt);
    end
`endif
    @(negedge clk);
    m_g = -1; m_ptr = 0; m_err = 0; m_cnt = 0;
    coin_in = '0;
    req  = 4'b0011;
    rstn = 1'b1;
    tick();
    n_assert++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL midsale_regrant: gnt=%b, required 0001", gnt);
    end
    req = '0;
  endtask

  task automatic test_sell_coin();
    do_reset();
    req = 4'b0001;
    tick();
    set_coin(0, 2'b10); tick();
    set_coin(0, 2'b10); tick();
    #1;
    n_assert++;
    if (vm_sell !== 1'b1 || vm_coin !== 2'b00 || sell_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL sell_coin_drop: vm_sell=%b vm_coin=%b sell_o=%b, required 1/00/0001",
               vm_sell, vm_coin, sell_o);
    end
    coin_in = '0;
    tick();
    n_assert++;
    if (core_credit !== 0) begin
      n_fail++;
      $display("FAIL sell_coin_credit: core credit=%0d, required 0", core_credit);
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [1:0]     c;
      logic [1:0]     ec;
      logic [N-1:0]   es;
      logic [2*N-1:0] ech;
      req     = N'($urandom_range(0, (1 << N) - 1));
      coin_in = '0;
      for (int p = 0; p < N; p++)
        coin_in[2*p +: 2] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      #1;
      ec  = 2'b00;
      es  = '0;
      ech = '0;
      if (m_g >= 0) begin
        c = coin_in[2*m_g +: 2];
        if (!vm_sell && c != 2'b11) ec = c;
        es[m_g]          = vm_sell;
        ech[2*m_g +: 2]  = vm_change;
      end
      n_assert++;
      if (vm_coin !== ec || sell_o !== es || change_o !== ech) begin
        n_fail++;
        $display("FAIL random_comb@%0d: vm_coin=%b sell_o=%b change_o=%b, required %b %b %b",
                 cyc, vm_coin, sell_o, change_o, ec, es, ech);
      end
      tick();
      n_assert++;
      if (gnt !== exp_gnt() || busy !== (m_g >= 0) || coin_err !== m_err) begin
        n_fail++;
        $display("FAIL random_reg@%0d: gnt=%b busy=%b coin_err=%b, required %b %b %b",
                 cyc, gnt, busy, coin_err, exp_gnt(), (m_g >= 0), m_err);
      end
`ifdef VM_ARB_SALE_CNT_EN
      n_assert++;
      if (sale_cnt !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL random_cnt@%0d: sale_cnt=%0d, required %0d", cyc, sale_cnt, m_cnt);
      end
`endif
    end
    req     = '0;
    coin_in = '0;
  endtask

  initial begin
    rstn    = 1'b0;
    req     = '0;
    coin_in = '0;
    m_g = -1; m_ptr = 0; m_cnt = 0; m_err = 0;
    test_reset();
    test_single();
    test_contention();
    test_change();
    test_illegal();
    test_midsale_reset();
    test_sell_coin();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
